// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller.
// A single full adder is reused once per clock cycle, LSB first. Operands
// are captured on an accepted start and shifted right past the adder. Each
// sum bit enters the result register at the MSB, so after WIDTH cycles bit 0
// of the result sits at sum[0].

// One-bit full adder. The controller instantiates it exactly once.
module full_adder (
   input  logic A,
   input  logic B,
   input  logic Cin,
   output logic S,
   output logic Cout
);

   assign S    = A ^ B ^ Cin;
   assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   // The bit counter needs at least one bit, even when WIDTH is 1.
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_shift;
   logic [WIDTH-1:0] b_shift;
   logic             carry;
   logic [CNT_W-1:0] count;

   logic             fa_s;
   logic             fa_cout;

   // This adder handles every bit position in turn: the current LSBs of the
   // operand shift registers plus the running carry.
   full_adder u_full_adder (
      .A    (a_shift[0]),
      .B    (b_shift[0]),
      .Cin  (carry),
      .S    (fa_s),
      .Cout (fa_cout)
   );

   // Sequence IDLE -> RUN (WIDTH cycles) -> DONE -> IDLE. busy and done are
   // registered alongside the state, so they always match the current state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         a_shift <= '0;
         b_shift <= '0;
         carry   <= 1'b0;
         count   <= '0;
         sum     <= '0;
         cout    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_shift <= a;
                  b_shift <= b;
                  carry   <= cin;
                  count   <= '0;
                  busy    <= 1'b1;
                  state   <= RUN;
               end else begin
                  busy <= 1'b0;
               end
            end

            RUN: begin
               sum     <= (sum >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
               carry   <= fa_cout;
               a_shift <= a_shift >> 1;
               b_shift <= b_shift >> 1;
               count   <= count + CNT_W'(1);
               if (count == LAST_BIT) begin
                  cout  <= fa_cout;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end

            DONE: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl.
// Two instances share the clock and reset:
//   - an 8-bit instance, used for the directed and random cases;
//   - a 2-bit instance, used for an exhaustive sweep.
// Expected results come from plain integer addition of the operands.

module tb_serial_adder_ctrl;

   localparam int W8 = 8;
   localparam int W2 = 2;

   logic          clk;
   logic          rst;

   logic          start8;
   logic [W8-1:0] a8;
   logic [W8-1:0] b8;
   logic          cin8;
   logic          busy8;
   logic          done8;
   logic [W8-1:0] sum8;
   logic          cout8;

   logic          start2;
   logic [W2-1:0] a2;
   logic [W2-1:0] b2;
   logic          cin2;
   logic          busy2;
   logic          done2;
   logic [W2-1:0] sum2;
   logic          cout2;

   int total_checks;
   int bad_checks;

   serial_adder_ctrl #(.WIDTH(W8)) dut8 (
      .clk   (clk),
      .rst   (rst),
      .start (start8),
      .a     (a8),
      .b     (b8),
      .cin   (cin8),
      .busy  (busy8),
      .done  (done8),
      .sum   (sum8),
      .cout  (cout8)
   );

   serial_adder_ctrl #(.WIDTH(W2)) dut2 (
      .clk   (clk),
      .rst   (rst),
      .start (start2),
      .a     (a2),
      .b     (b2),
      .cin   (cin2),
      .busy  (busy2),
      .done  (done2),
      .sum   (sum2),
      .cout  (cout2)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count one comparison and report it when observed and expected differ.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total_checks++;
      if (observed !== expected) begin
         bad_checks++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Advance one rising edge, then settle 1 unit past it before sampling.
   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Run one 8-bit addition.
   //   scramble: change a/b/cin after acceptance (result must not change).
   //   hammer:   keep start high through RUN (it must be ignored).
   task automatic applyStimulus(input logic [W8-1:0] a_v, input logic [W8-1:0] b_v,
                                input logic cin_v, input bit scramble, input bit hammer);
      logic [W8:0] expected;
      int          busy_cnt;
      int          done_cnt;
      expected = {1'b0, a_v} + {1'b0, b_v} + {{W8{1'b0}}, cin_v};
      a8 = a_v;
      b8 = b_v;
      cin8 = cin_v;
      start8 = 1'b1;
      stepCycle();
      start8 = hammer;
      if (scramble) begin
         a8 = '0;
         b8 = '0;
         cin8 = ~cin_v;
      end
      busy_cnt = 0;
      done_cnt = 0;
      for (int i = 0; i < W8; i++) begin
         if (busy8 === 1'b1) busy_cnt++;
         if (done8 === 1'b1) done_cnt++;
         stepCycle();
      end
      checkOutput("busy_cycles", busy_cnt, W8);
      checkOutput("done_during_run", done_cnt, 0);
      checkOutput("done_pulse", {31'd0, done8}, 1);
      checkOutput("busy_at_done", {31'd0, busy8}, 0);
      checkOutput("sum", {24'd0, sum8}, {24'd0, expected[W8-1:0]});
      checkOutput("cout", {31'd0, cout8}, {31'd0, expected[W8]});
      start8 = 1'b0;
      stepCycle();
      checkOutput("done_one_cycle", {31'd0, done8}, 0);
      checkOutput("idle_not_busy", {31'd0, busy8}, 0);
      checkOutput("sum_held", {24'd0, sum8}, {24'd0, expected[W8-1:0]});
   endtask

   // Run one 2-bit addition, waiting a bounded number of cycles for done.
   task automatic applyStimulus2(input logic [W2-1:0] a_v, input logic [W2-1:0] b_v,
                                 input logic cin_v);
      int          expected;
      int          cycles;
      logic [W2:0] result;
      expected = int'(a_v) + int'(b_v) + int'(cin_v);
      a2 = a_v;
      b2 = b_v;
      cin2 = cin_v;
      start2 = 1'b1;
      stepCycle();
      start2 = 1'b0;
      cycles = 0;
      while (done2 !== 1'b1 && cycles < 10) begin
         stepCycle();
         cycles++;
      end
      if (done2 !== 1'b1) begin
         checkOutput("w2_timeout", 0, 1);
      end else begin
         result = {cout2, sum2};
         checkOutput("w2_latency", cycles, W2);
         checkOutput("w2_result", {29'd0, result}, expected);
      end
      stepCycle();
   endtask

   // Main stimulus sequence.
   initial begin
      int          t;
      int          done_cnt;
      int          busy_cnt;
      int          first_done;
      int          second_done;
      logic [W8:0] second_result;

      total_checks = 0;
      bad_checks = 0;
      rst = 1'b1;
      start8 = 1'b0;
      a8 = '0;
      b8 = '0;
      cin8 = 1'b0;
      start2 = 1'b0;
      a2 = '0;
      b2 = '0;
      cin2 = 1'b0;
      stepCycle();
      stepCycle();

      // Reset state.
      checkOutput("rst_busy", {31'd0, busy8}, 0);
      checkOutput("rst_done", {31'd0, done8}, 0);
      checkOutput("rst_sum", {24'd0, sum8}, 0);
      checkOutput("rst_cout", {31'd0, cout8}, 0);
      rst = 1'b0;
      stepCycle();

      // Directed cases: carry ripple, scrambled operands, all ones,
      // and start hammered throughout RUN.
      applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
      applyStimulus(8'h5A, 8'h33, 1'b1, 1'b1, 1'b0);
      applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
      applyStimulus(8'h3C, 8'hA7, 1'b0, 1'b0, 1'b1);

      // Back-to-back issue with start held continuously. The second
      // operands are presented while the first result is on the outputs.
      a8 = 8'hFF;
      b8 = 8'hFF;
      cin8 = 1'b1;
      start8 = 1'b1;
      done_cnt = 0;
      first_done = -1;
      second_done = -1;
      second_result = '0;
      for (t = 1; t <= 2 * W8 + 6; t++) begin
         stepCycle();
         if (done8 === 1'b1) begin
            done_cnt++;
            if (first_done < 0) begin
               first_done = t;
               checkOutput("b2b_first", {23'd0, cout8, sum8}, 32'h1FF);
               a8 = 8'h12;
               b8 = 8'h34;
               cin8 = 1'b0;
            end else if (second_done < 0) begin
               second_done = t;
               second_result = {cout8, sum8};
               start8 = 1'b0;
            end
         end
      end
      start8 = 1'b0;
      checkOutput("b2b_done_count", done_cnt, 2);
      checkOutput("b2b_interval", second_done - first_done, W8 + 2);
      checkOutput("b2b_second", {23'd0, second_result}, 32'h046);

      // Reset during the fourth RUN cycle aborts the operation.
      a8 = 8'h77;
      b8 = 8'h11;
      cin8 = 1'b1;
      start8 = 1'b1;
      stepCycle();
      start8 = 1'b0;
      stepCycle();
      stepCycle();
      stepCycle();
      rst = 1'b1;
      stepCycle();
      rst = 1'b0;
      checkOutput("abort_busy", {31'd0, busy8}, 0);
      checkOutput("abort_done", {31'd0, done8}, 0);
      checkOutput("abort_sum", {24'd0, sum8}, 0);
      checkOutput("abort_cout", {31'd0, cout8}, 0);
      done_cnt = 0;
      busy_cnt = 0;
      for (int i = 0; i < W8 + 3; i++) begin
         stepCycle();
         if (done8 === 1'b1) done_cnt++;
         if (busy8 === 1'b1) busy_cnt++;
      end
      checkOutput("abort_no_done", done_cnt, 0);
      checkOutput("abort_no_busy", busy_cnt, 0);

      // A start on the same edge as reset must be ignored.
      rst = 1'b1;
      start8 = 1'b1;
      stepCycle();
      rst = 1'b0;
      start8 = 1'b0;
      checkOutput("rst_start_busy", {31'd0, busy8}, 0);
      stepCycle();
      checkOutput("rst_start_idle", {31'd0, busy8}, 0);

      // Random operands, with random scrambling and hammering.
      for (int n = 0; n < 20; n++) begin
         applyStimulus(W8'($urandom), W8'($urandom), 1'($urandom),
                       1'($urandom), 1'($urandom));
      end

      // Exhaustive sweep of the 2-bit instance.
      for (int i = 0; i < 32; i++) begin
         applyStimulus2(W2'(i >> 3), W2'(i >> 1), 1'(i));
      end

      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule
